// File: rtl/display_pkg.sv
// Shared definitions for the display datapath: step-mode encoding and
// the shift engine's run-control state type.
package display_pkg;

  localparam int unsigned MODE_W = 3;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_HOLD  = 3'd0;
  localparam mode_t MODE_ZERO  = 3'd1;
  localparam mode_t MODE_FILL  = 3'd2;
  localparam mode_t MODE_ARITH = 3'd3;
  localparam mode_t MODE_ROT   = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/digit_step_comb.sv
// Combinational one-digit step: computes the next digit vector for a single
// shift/rotate operation. Digits are treated as opaque DW-bit fields.
module digit_step_comb
  import display_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DW     = 4
) (
  input  logic [DIGITS*DW-1:0] q,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 dir,
  input  logic [DW-1:0]        fill,
  output logic [DIGITS*DW-1:0] q_nxt_c
);

  localparam int unsigned TOP = DIGITS - 1;

  logic [DW-1:0] ins_up_c;
  logic [DW-1:0] ins_dn_c;
  logic          shift_en_c;

  // Digit entering at index 0 (dir=1) or at index TOP (dir=0)
  always_comb begin
    ins_up_c   = '0;
    ins_dn_c   = '0;
    shift_en_c = 1'b1;
    case (mode)
      MODE_ZERO: begin
        ins_up_c = '0;
        ins_dn_c = '0;
      end
      MODE_FILL: begin
        ins_up_c = fill;
        ins_dn_c = fill;
      end
      MODE_ARITH: begin
        ins_up_c = q[0 +: DW];
        ins_dn_c = q[TOP*DW +: DW];
      end
      MODE_ROT: begin
        ins_up_c = q[TOP*DW +: DW];
        ins_dn_c = q[0 +: DW];
      end
      default: shift_en_c = 1'b0;
    endcase
  end

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [DW-1:0] up_src;
    logic [DW-1:0] dn_src;

    if (i == 0) begin : g_up_edge
      assign up_src = ins_up_c;
    end else begin : g_up_mid
      assign up_src = q[(i-1)*DW +: DW];
    end

    if (i == TOP) begin : g_dn_edge
      assign dn_src = ins_dn_c;
    end else begin : g_dn_mid
      assign dn_src = q[(i+1)*DW +: DW];
    end

    assign q_nxt_c[i*DW +: DW] = !shift_en_c ? q[i*DW +: DW]
                               : (dir ? up_src : dn_src);
  end

endmodule

// File: rtl/digit_shift_engine.sv
// N-digit shift/rotate register for the segment display path, stepped by
// divider ticks under a start/busy/done run controller.
module digit_shift_engine
  import display_pkg::*;
#(
  parameter int unsigned              DIGITS        = 4,
  parameter int unsigned              DW            = 4,
  parameter int unsigned              STEP_W        = 8,
  parameter logic [DIGITS*DW-1:0]     RESET_PATTERN = 'h0101
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic [MODE_W-1:0]    mode,
  input  logic                 dir,
  input  logic [DW-1:0]        fill,
  input  logic                 load,
  input  logic [DIGITS*DW-1:0] load_data,
  input  logic                 start,
  input  logic                 abort,
  input  logic [STEP_W-1:0]    steps,
  output logic [DIGITS*DW-1:0] q,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned QW = DIGITS * DW;

  state_t            state, state_nxt;
  logic [STEP_W-1:0] cnt, cnt_nxt;
  logic [MODE_W-1:0] mode_l, mode_nxt;
  logic              dir_l, dir_nxt;
  logic [DW-1:0]     fill_l, fill_nxt;
  logic [QW-1:0]     q_nxt;
  logic              busy_nxt;
  logic              done_nxt;
  logic [QW-1:0]     step_q_c;

  digit_step_comb #(
    .DIGITS (DIGITS),
    .DW     (DW)
  ) u_step (
    .q       (q),
    .mode    (mode_l),
    .dir     (dir_l),
    .fill    (fill_l),
    .q_nxt_c (step_q_c)
  );

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mode_l <= MODE_HOLD;
      dir_l  <= 1'b0;
      fill_l <= '0;
      q      <= RESET_PATTERN;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      mode_l <= mode_nxt;
      dir_l  <= dir_nxt;
      fill_l <= fill_nxt;
      q      <= q_nxt;
      busy   <= busy_nxt;
      done   <= done_nxt;
    end
  end

  // Next-state and next-output logic; busy/done track the state being entered
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    mode_nxt  = mode_l;
    dir_nxt   = dir_l;
    fill_nxt  = fill_l;
    q_nxt     = q;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (load) begin
          q_nxt = load_data;
        end else if (start) begin
          mode_nxt = mode;
          dir_nxt  = dir;
          fill_nxt = fill;
          cnt_nxt  = steps;
          if (steps == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = ST_RUN;
            busy_nxt  = 1'b1;
          end
        end
      end

      ST_RUN: begin
        busy_nxt = 1'b1;
        if (abort) begin
          state_nxt = ST_IDLE;
          busy_nxt  = 1'b0;
        end else if (tick) begin
          q_nxt   = step_q_c;
          cnt_nxt = cnt - STEP_W'(1);
          if (cnt == STEP_W'(1)) begin
            state_nxt = ST_DONE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_nxt = ST_IDLE;
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_digit_shift_engine.sv
// Self-checking bench for digit_shift_engine: single-step vector table,
// hand-written multi-cycle sequences and a randomized run against a queue model.
module tb_digit_shift_engine;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [2:0]  mode;
  logic        dir;
  logic [3:0]  fill4;
  logic [4:0]  fill6;
  logic        load;
  logic [15:0] ld4;
  logic [29:0] ld6;
  logic        start;
  logic        abort;
  logic [7:0]  steps;
  logic [15:0] q4;
  logic [29:0] q6;
  logic        busy4, done4, busy6, done6;

  int n_tests = 0;
  int n_fail  = 0;

  digit_shift_engine #(.DIGITS(4), .DW(4), .STEP_W(8)) dut4 (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .dir(dir), .fill(fill4),
    .load(load), .load_data(ld4), .start(start), .abort(abort), .steps(steps),
    .q(q4), .busy(busy4), .done(done4)
  );

  digit_shift_engine #(.DIGITS(6), .DW(5), .STEP_W(8)) dut6 (
    .clk(clk), .rst(rst), .tick(tick), .mode(mode), .dir(dir), .fill(fill6),
    .load(load), .load_data(ld6), .start(start), .abort(abort), .steps(steps),
    .q(q6), .busy(busy6), .done(done6)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: digit list as a queue, shifted by pushing the inserted digit
  // on one end and dropping the one that falls off the other end.
  function automatic logic [63:0] ref_step(logic [63:0] v, int n, int w,
                                           int md, bit dr, int fl);
    int d[$];
    int ins;
    logic [63:0] mask, tmp, r;
    mask = (64'd1 << w) - 64'd1;
    for (int i = 0; i < n; i++) begin
      tmp = (v >> (i * w)) & mask;
      d.push_back(int'(tmp[31:0]));
    end
    if (md < 1 || md > 4) return v;
    case (md)
      1:       ins = 0;
      2:       ins = fl;
      3:       ins = dr ? d[0] : d[n-1];
      default: ins = dr ? d[n-1] : d[0];
    endcase
    if (dr) begin
      d.push_front(ins);
      void'(d.pop_back());
    end else begin
      d.push_back(ins);
      void'(d.pop_front());
    end
    r = '0;
    for (int i = 0; i < n; i++) begin
      tmp = 64'(d[i]);
      r = r | ((tmp & mask) << (i * w));
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tick = 1'b0; load = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v4, input logic [29:0] v6);
    ld4 = v4; ld6 = v6; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic do_start(input logic [2:0] md, input logic dr, input logic [3:0] fl,
                          input logic [7:0] st);
    mode = md; dir = dr; fill4 = fl; steps = st; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  typedef struct {
    logic [15:0] ld;
    logic [2:0]  md;
    logic        dr;
    logic [3:0]  fl;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  // Random-phase model state
  logic [15:0] m_q;
  bit          m_run, m_done, m_dr;
  int          m_left, m_md, m_fl;

  task automatic model_edge();
    if (m_done) begin
      m_done = 1'b0;
    end else if (!m_run) begin
      if (load) m_q = ld4;
      else if (start) begin
        m_md = int'(mode); m_dr = dir; m_fl = int'(fill4);
        if (steps == 8'd0) m_done = 1'b1;
        else begin
          m_run = 1'b1; m_left = int'(steps);
        end
      end
    end else if (abort) begin
      m_run = 1'b0;
    end else if (tick) begin
      m_q = 16'(ref_step(64'(m_q), 4, 4, m_md, m_dr, m_fl));
      m_left--;
      if (m_left == 0) begin
        m_run = 1'b0; m_done = 1'b1;
      end
    end
  endtask

  initial begin
    logic [15:0] q_hold;
    logic [29:0] v6, e6;
    int          done_cnt;

    vecs[0] = '{16'h4321, 3'd1, 1'b1, 4'h0, 16'h3210};
    vecs[1] = '{16'h4321, 3'd1, 1'b0, 4'h0, 16'h0432};
    vecs[2] = '{16'h9005, 3'd3, 1'b1, 4'h0, 16'h0055};
    vecs[3] = '{16'h0055, 3'd2, 1'b0, 4'hA, 16'hA005};
    vecs[4] = '{16'h4321, 3'd4, 1'b1, 4'h0, 16'h3214};
    vecs[5] = '{16'h4321, 3'd4, 1'b0, 4'h0, 16'h1432};
    vecs[6] = '{16'h4321, 3'd0, 1'b1, 4'h7, 16'h4321};
    vecs[7] = '{16'h4321, 3'd6, 1'b0, 4'h7, 16'h4321};
    vecs[8] = '{16'h8001, 3'd3, 1'b0, 4'h0, 16'h8800};
    vecs[9] = '{16'h1234, 3'd2, 1'b1, 4'hF, 16'h234F};

    rst = 1'b1; idle_inputs();
    mode = 3'd0; dir = 1'b0; fill4 = '0; fill6 = '0; ld4 = '0; ld6 = '0; steps = '0;
    cyc();
    rst = 1'b0;
    check("reset_q", 64'(q4), 64'h0101);
    check("reset_busy", 64'(busy4), 64'd0);
    check("reset_done", 64'(done4), 64'd0);
    check("reset_q6", 64'(q6), 64'h0101);

    // Single-step table
    for (int k = 0; k < 10; k++) begin
      do_load(vecs[k].ld, 30'd0);
      do_start(vecs[k].md, vecs[k].dr, vecs[k].fl, 8'd1);
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      check($sformatf("vec%0d_q", k), 64'(q4), 64'(vecs[k].exp));
      check($sformatf("vec%0d_done", k), 64'(done4), 64'd1);
      cyc();
    end

    // Zero-shift up, steps=2, tick on the start edge plus three ticks
    do_load(16'h4321, 30'd0);
    tick = 1'b1;
    do_start(3'd1, 1'b1, 4'h0, 8'd2);
    check("zs_start_noop", 64'(q4), 64'h4321);
    check("zs_busy", 64'(busy4), 64'd1);
    done_cnt = 0;
    cyc(); done_cnt += int'(done4);
    check("zs_t1", 64'(q4), 64'h3210);
    cyc(); done_cnt += int'(done4);
    check("zs_t2", 64'(q4), 64'h2100);
    check("zs_busy_end", 64'(busy4), 64'd0);
    cyc(); done_cnt += int'(done4);
    check("zs_t3_ignored", 64'(q4), 64'h2100);
    tick = 1'b0;
    cyc(); done_cnt += int'(done4);
    check("zs_done_pulses", 64'(done_cnt), 64'd1);

    // Rotate down, 4 steps back to the loaded value
    do_load(16'h4321, 30'd0);
    do_start(3'd4, 1'b0, 4'h0, 8'd4);
    tick = 1'b1;
    cyc(); check("rot_t1", 64'(q4), 64'h1432);
    cyc(); check("rot_t2", 64'(q4), 64'h2143);
    cyc(); check("rot_t3", 64'(q4), 64'h3214);
    tick = 1'b0; mode = 3'd1; dir = 1'b1;
    cyc(); check("rot_gap_latched", 64'(q4), 64'h3214);
    tick = 1'b1;
    cyc(); check("rot_t4", 64'(q4), 64'h4321);
    check("rot_done", 64'(done4), 64'd1);
    tick = 1'b0;
    cyc();

    // Abort with a coincident tick, plus load ignored during RUN
    do_load(16'h4321, 30'd0);
    do_start(3'd4, 1'b1, 4'h0, 8'd5);
    tick = 1'b1;
    cyc(); cyc();
    check("ab_two", 64'(q4), 64'h2143);
    tick = 1'b0; load = 1'b1; ld4 = 16'hFFFF;
    cyc();
    load = 1'b0;
    check("ab_load_ignored", 64'(q4), 64'h2143);
    tick = 1'b1; abort = 1'b1;
    cyc();
    idle_inputs();
    check("ab_frozen", 64'(q4), 64'h2143);
    check("ab_busy", 64'(busy4), 64'd0);
    check("ab_done0", 64'(done4), 64'd0);
    cyc();
    check("ab_done1", 64'(done4), 64'd0);

    // steps=0 start
    q_hold = q4;
    tick = 1'b1;
    do_start(3'd1, 1'b1, 4'h0, 8'd0);
    check("s0_done", 64'(done4), 64'd1);
    check("s0_busy", 64'(busy4), 64'd0);
    check("s0_q", 64'(q4), 64'(q_hold));
    cyc();
    tick = 1'b0;
    check("s0_done_low", 64'(done4), 64'd0);

    // load and start together: load wins, stays idle
    ld4 = 16'h5A5A; load = 1'b1; steps = 8'd3; mode = 3'd4; start = 1'b1;
    cyc();
    idle_inputs();
    check("ls_q", 64'(q4), 64'h5A5A);
    check("ls_busy", 64'(busy4), 64'd0);
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    check("ls_idle_q", 64'(q4), 64'h5A5A);
    check("ls_idle_busy", 64'(busy4), 64'd0);

    // Asynchronous reset mid-run
    do_start(3'd1, 1'b1, 4'h0, 8'd4);
    #1 rst = 1'b1;
    #1;
    check("arst_q", 64'(q4), 64'h0101);
    check("arst_busy", 64'(busy4), 64'd0);
    rst = 1'b0;
    cyc();

    // Six-digit, five-bit rotate up restores the loaded value
    v6 = 30'($urandom);
    do_load(16'h0000, v6);
    do_start(3'd4, 1'b1, 4'h0, 8'd6);
    e6 = v6;
    tick = 1'b1;
    for (int k = 0; k < 6; k++) begin
      e6 = 30'(ref_step(64'(e6), 6, 5, 4, 1'b1, 0));
      cyc();
      check($sformatf("r6_t%0d", k + 1), 64'(q6), 64'(e6));
    end
    tick = 1'b0;
    check("r6_restore", 64'(q6), 64'(v6));
    check("r6_done", 64'(done6), 64'd1);
    cyc();

    // Randomized run against the model
    rst = 1'b1;
    #1 rst = 1'b0;
    m_q = 16'h0101; m_run = 1'b0; m_done = 1'b0; m_left = 0;
    m_md = 0; m_dr = 1'b0; m_fl = 0;
    for (int c = 0; c < 400; c++) begin
      tick  = 1'($urandom_range(0, 1));
      load  = ($urandom_range(0, 9) == 0);
      start = ($urandom_range(0, 3) == 0);
      abort = ($urandom_range(0, 24) == 0);
      mode  = 3'($urandom_range(0, 7));
      dir   = 1'($urandom_range(0, 1));
      fill4 = 4'($urandom);
      steps = 8'($urandom_range(0, 4));
      ld4   = 16'($urandom);
      model_edge();
      cyc();
      check("rnd_q", 64'(q4), 64'(m_q));
      check("rnd_busy", 64'(busy4), 64'(m_run));
      check("rnd_done", 64'(done4), 64'(m_done));
    end
    idle_inputs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
